// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX/MEM/WB destination tracking, operand forwarding, load-use stall, redirect flush and boot hold.
module hazard_ctrl #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_reg_wen_i,
    input  logic              id_is_load_i,
    input  logic              ex_redirect_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic [1:0]        state_o
);
    localparam int CW = 8;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } slot_t;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    slot_t             ex_q, mem_q, wb_q, id_slot;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
    logic              ex_use1_q, ex_use2_q;
    logic              ex_wr, mem_wr, wb_wr, load_use, redir, accept;
    assign id_slot = '{valid: 1'b1, rd: id_rd_i, wen: id_reg_wen_i, load: id_is_load_i};
    assign ex_wr   = ex_q.valid && ex_q.wen && ex_q.rd != '0;
    assign mem_wr  = mem_q.valid && mem_q.wen && mem_q.rd != '0;
    assign wb_wr   = wb_q.valid && wb_q.wen && wb_q.rd != '0;
    // MEM carries the ALU result only, so it outranks the older WB value.
    assign fwd_a_sel_o = !(ex_q.valid && ex_use1_q) ? 2'b00 :
                         mem_wr && mem_q.rd == ex_rs1_q ? 2'b01 :
                         wb_wr && wb_q.rd == ex_rs1_q ? 2'b10 : 2'b00;
    assign fwd_b_sel_o = !(ex_q.valid && ex_use2_q) ? 2'b00 :
                         mem_wr && mem_q.rd == ex_rs2_q ? 2'b01 :
                         wb_wr && wb_q.rd == ex_rs2_q ? 2'b10 : 2'b00;
    assign load_use = id_valid_i && ex_wr && ex_q.load &&
                      ((id_use_rs1_i && id_rs1_i == ex_q.rd) || (id_use_rs2_i && id_rs2_i == ex_q.rd));
    assign redir    = state_q == RUN && ex_redirect_i && ex_q.valid;
    assign flush_o  = redir || state_q == FLUSH;
    assign stall_o  = state_q == BOOT || (state_q == RUN && load_use && !redir);
    assign bubble_o = stall_o || flush_o;
    assign state_o  = state_q;
    assign accept   = id_valid_i && !bubble_o;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q <= CW'(1) ? RUN : BOOT;
            end
            RUN: begin
                cnt_d   = redir ? CW'(FLUSH_CYCLES - 1) : cnt_q;
                state_d = redir && FLUSH_CYCLES > 1 ? FLUSH : RUN;
            end
            FLUSH: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q <= CW'(1) ? RUN : FLUSH;
            end
            default: state_d = BOOT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            cnt_q     <= CW'(BOOT_CYCLES);
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_q      <= accept ? id_slot : '0;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            ex_rs1_q  <= id_rs1_i;
            ex_rs2_q  <= id_rs2_i;
            ex_use1_q <= id_use_rs1_i;
            ex_use2_q <= id_use_rs2_i;
        end
    end
endmodule
